// File: rtl/ber_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ber_run_controller
//  Purpose  : Sequences one BER measurement run. It loads the Markov
//             probability table into the parallel BER core, holds the core
//             in reset while it settles, enables it until a stop threshold
//             (or optional timeout) is reached, and then snapshots the core
//             counters. Abort cancels a run in progress.
//  Options  : define BER_CTRL_TIMEOUT_EN to enable the cfg_max_cycles RUN
//             timeout (stop reason 3). Without it cfg_max_cycles is ignored.
//             The port list is the same in both builds.
//  Ports    :
//    clk, rst                 - clock, synchronous active-high reset
//    start, abort             - run request pulse / cancel current run
//    cfg_target_bits          - bit-count stop threshold (0 = disabled)
//    cfg_target_frame_errors  - frame-error stop threshold (0 = disabled)
//    cfg_max_cycles           - RUN timeout in cycles (0 = unlimited)
//    prob_valid/data/ready    - probability-table write stream
//    core_rstn, core_en       - core reset (active low) and enable
//    probability_in/_idx      - table word and index presented to the core
//    total_*                  - live core counters
//    snap_*                   - counters latched when the run stops
//    busy, done, aborted      - run status
//    stop_reason              - 1 bits, 2 frame errors, 3 timeout
//    run_cycles               - RUN cycles elapsed (saturating)
//  Revision : 1.0 - initial release
// ============================================================================
module ber_run_controller #(
    parameter int N_PROB        = 64,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [63:0] cfg_target_bits,
    input  logic [63:0] cfg_target_frame_errors,
    input  logic [47:0] cfg_max_cycles,
    input  logic        prob_valid,
    input  logic [63:0] prob_data,
    output logic        prob_ready,
    output logic        core_rstn,
    output logic        core_en,
    output logic [63:0] probability_in,
    output logic [31:0] probability_idx,
    input  logic [63:0] total_bits,
    input  logic [63:0] total_bit_errors_pre,
    input  logic [63:0] total_bit_errors_post,
    input  logic [63:0] total_frames,
    input  logic [63:0] total_frame_errors,
    output logic [63:0] snap_bits,
    output logic [63:0] snap_err_pre,
    output logic [63:0] snap_err_post,
    output logic [63:0] snap_frames,
    output logic [63:0] snap_frame_err,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [1:0]  stop_reason,
    output logic [47:0] run_cycles
);

    localparam int              c_settle_w    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_settle_w-1:0] c_settle_last =
        c_settle_w'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [31:0]     c_word_last   = 32'(N_PROB - 1);
    localparam logic [47:0]     c_run_max     = {48{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [31:0]             r_word_cnt;
    logic [c_settle_w-1:0]   r_settle_cnt;
    logic                    w_xfer;
    logic                    w_timeout;
    logic [1:0]              w_reason;
    logic [47:0]             w_run_inc;

    // prob_ready is registered and high exactly while in LOAD
    assign w_xfer    = prob_ready & prob_valid;
    assign w_run_inc = (run_cycles == c_run_max) ? run_cycles : run_cycles + 48'd1;

`ifdef BER_CTRL_TIMEOUT_EN
    // Compare against the post-increment count so a limit of M gives
    // exactly M enabled core cycles.
    assign w_timeout = (cfg_max_cycles != 48'd0) && (w_run_inc == cfg_max_cycles);
`else
    logic w_unused_cfg_max;
    assign w_unused_cfg_max = ^cfg_max_cycles;
    assign w_timeout        = 1'b0;
`endif

    // Stop reason with fixed priority: bits, then frame errors, then timeout
    always_comb begin
        w_reason = 2'd0;
        if ((cfg_target_bits != 64'd0) && (total_bits >= cfg_target_bits)) begin
            w_reason = 2'd1;
        end else if ((cfg_target_frame_errors != 64'd0) &&
                     (total_frame_errors >= cfg_target_frame_errors)) begin
            w_reason = 2'd2;
        end else if (w_timeout) begin
            w_reason = 2'd3;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_xfer && (r_word_cnt == c_word_last)) begin
                    w_state_next = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_reason != 2'd0) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, datapath and status registers. Status flags are decoded from
    // the next state so they change in the same cycle as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_word_cnt      <= 32'd0;
            r_settle_cnt    <= '0;
            prob_ready      <= 1'b0;
            core_rstn       <= 1'b0;
            core_en         <= 1'b0;
            probability_in  <= 64'd0;
            probability_idx <= 32'd0;
            snap_bits       <= 64'd0;
            snap_err_pre    <= 64'd0;
            snap_err_post   <= 64'd0;
            snap_frames     <= 64'd0;
            snap_frame_err  <= 64'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            aborted         <= 1'b0;
            stop_reason     <= 2'd0;
            run_cycles      <= 48'd0;
        end else begin
            r_state    <= w_state_next;
            prob_ready <= (w_state_next == S_LOAD);
            core_en    <= (w_state_next == S_RUN);
            core_rstn  <= (w_state_next == S_RUN) || (w_state_next == S_STOP) ||
                          (w_state_next == S_DONE);
            busy       <= (w_state_next == S_LOAD) || (w_state_next == S_SETTLE) ||
                          (w_state_next == S_RUN)  || (w_state_next == S_STOP);
            done       <= (w_state_next == S_DONE);

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_word_cnt   <= 32'd0;
                        r_settle_cnt <= '0;
                        aborted      <= 1'b0;
                        stop_reason  <= 2'd0;
                        run_cycles   <= 48'd0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (w_xfer) begin
                        probability_in  <= prob_data;
                        probability_idx <= r_word_cnt;
                        r_word_cnt      <= r_word_cnt + 32'd1;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    run_cycles <= w_run_inc;
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (w_reason != 2'd0) begin
                        stop_reason <= w_reason;
                    end
                end
                S_STOP: begin
                    snap_bits      <= total_bits;
                    snap_err_pre   <= total_bit_errors_pre;
                    snap_err_post  <= total_bit_errors_post;
                    snap_frames    <= total_frames;
                    snap_frame_err <= total_frame_errors;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ber_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ber_run_controller
//  Purpose  : Self-checking bench for ber_run_controller. Each run's stop
//             cycle and reason are predicted arithmetically from the ramp
//             rates and thresholds; stimulus gaps and values are random.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ber_run_controller;

    localparam int c_n_prob    = 4;
    localparam int c_settle    = 16;
    localparam int c_run_limit = 1100;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [63:0] cfg_target_bits, cfg_target_frame_errors;
    logic [47:0] cfg_max_cycles;
    logic        prob_valid;
    logic [63:0] prob_data;
    logic        prob_ready, core_rstn, core_en;
    logic [63:0] probability_in;
    logic [31:0] probability_idx;
    logic [63:0] total_bits, total_bit_errors_pre, total_bit_errors_post;
    logic [63:0] total_frames, total_frame_errors;
    logic [63:0] snap_bits, snap_err_pre, snap_err_post, snap_frames, snap_frame_err;
    logic        busy, done, aborted;
    logic [1:0]  stop_reason;
    logic [47:0] run_cycles;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] exp_snap [5];

    always #5 clk = ~clk;

    ber_run_controller #(
        .N_PROB        (c_n_prob),
        .SETTLE_CYCLES (c_settle)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .abort                   (abort),
        .cfg_target_bits         (cfg_target_bits),
        .cfg_target_frame_errors (cfg_target_frame_errors),
        .cfg_max_cycles          (cfg_max_cycles),
        .prob_valid              (prob_valid),
        .prob_data               (prob_data),
        .prob_ready              (prob_ready),
        .core_rstn               (core_rstn),
        .core_en                 (core_en),
        .probability_in          (probability_in),
        .probability_idx         (probability_idx),
        .total_bits              (total_bits),
        .total_bit_errors_pre    (total_bit_errors_pre),
        .total_bit_errors_post   (total_bit_errors_post),
        .total_frames            (total_frames),
        .total_frame_errors      (total_frame_errors),
        .snap_bits               (snap_bits),
        .snap_err_pre            (snap_err_pre),
        .snap_err_post           (snap_err_post),
        .snap_frames             (snap_frames),
        .snap_frame_err          (snap_frame_err),
        .busy                    (busy),
        .done                    (done),
        .aborted                 (aborted),
        .stop_reason             (stop_reason),
        .run_cycles              (run_cycles)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs are sampled and inputs changed 1 time unit after each edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_snaps(input string tag);
        check_eq({tag, ":snap_bits"},      snap_bits,      exp_snap[0]);
        check_eq({tag, ":snap_err_pre"},   snap_err_pre,   exp_snap[1]);
        check_eq({tag, ":snap_err_post"},  snap_err_post,  exp_snap[2]);
        check_eq({tag, ":snap_frames"},    snap_frames,    exp_snap[3]);
        check_eq({tag, ":snap_frame_err"}, snap_frame_err, exp_snap[4]);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, ":core_rstn"},   core_rstn,       64'd0);
        check_eq({tag, ":core_en"},     core_en,         64'd0);
        check_eq({tag, ":prob_ready"},  prob_ready,      64'd0);
        check_eq({tag, ":prob_in"},     probability_in,  64'd0);
        check_eq({tag, ":prob_idx"},    probability_idx, 64'd0);
        check_eq({tag, ":busy"},        busy,            64'd0);
        check_eq({tag, ":done"},        done,            64'd0);
        check_eq({tag, ":aborted"},     aborted,         64'd0);
        check_eq({tag, ":stop_reason"}, stop_reason,     64'd0);
        check_eq({tag, ":run_cycles"},  run_cycles,      64'd0);
        for (int i = 0; i < 5; i++) exp_snap[i] = 64'd0;
        check_snaps(tag);
    endtask

    // Number of RUN cycles until a ramp of 'step' per cycle reaches 'tgt'
    // (0 when the threshold is disabled).
    function automatic int unsigned first_k(input longint unsigned tgt, input longint unsigned step);
        if (tgt == 0) return 0;
        return int'((tgt + step - 1) / step);
    endfunction

    // Reference: which RUN cycle ends the run and why (k_stop 0 = never)
    task automatic predict_stop(input longint unsigned tgt_b, input longint unsigned tgt_f,
                                input longint unsigned step_b, input longint unsigned step_f,
                                input logic [47:0] max_c,
                                output int unsigned k_stop, output logic [1:0] reason);
        int unsigned kb, kf, kt;
        kb = first_k(tgt_b, step_b);
        kf = first_k(tgt_f, step_f);
`ifdef BER_CTRL_TIMEOUT_EN
        kt = int'(max_c);
`else
        kt = 0;
`endif
        k_stop = 0;
        if (kb != 0 && (k_stop == 0 || kb < k_stop)) k_stop = kb;
        if (kf != 0 && (k_stop == 0 || kf < k_stop)) k_stop = kf;
        if (kt != 0 && (k_stop == 0 || kt < k_stop)) k_stop = kt;
        if (k_stop == 0)                  reason = 2'd0;
        else if (kb == k_stop)            reason = 2'd1;
        else if (kf == k_stop)            reason = 2'd2;
        else                              reason = 2'd3;
    endtask

    // One complete run. load_abort_after >= 0 aborts in LOAD after that many
    // words; run_abort_k != 0 aborts (or resets, if use_rst) in that RUN cycle.
    task automatic do_run(input string tag,
                          input longint unsigned tgt_b, input longint unsigned tgt_f,
                          input longint unsigned step_b, input longint unsigned step_f,
                          input logic [47:0] max_c,
                          input int load_abort_after, input int unsigned run_abort_k,
                          input bit use_rst);
        int unsigned k_stop, k_exp, n, k, gaps;
        logic [1:0]  reason;
        logic [63:0] word;
        logic [63:0] snapv [5];

        cfg_target_bits         = tgt_b;
        cfg_target_frame_errors = tgt_f;
        cfg_max_cycles          = max_c;
        total_bits = 0; total_bit_errors_pre = 0; total_bit_errors_post = 0;
        total_frames = 0; total_frame_errors = 0;

        start = 1'b1; tick(); start = 1'b0;
        check_eq({tag, ":load_ready"},   prob_ready,  64'd1);
        check_eq({tag, ":load_busy"},    busy,        64'd1);
        check_eq({tag, ":load_done"},    done,        64'd0);
        check_eq({tag, ":load_aborted"}, aborted,     64'd0);
        check_eq({tag, ":load_reason"},  stop_reason, 64'd0);
        check_eq({tag, ":load_cycles"},  run_cycles,  64'd0);
        check_eq({tag, ":load_rstn"},    core_rstn,   64'd0);

        for (int w = 0; w < c_n_prob; w++) begin
            if (w == load_abort_after) begin
                abort = 1'b1; tick(); abort = 1'b0;
                check_eq({tag, ":labort_busy"},    busy,       64'd0);
                check_eq({tag, ":labort_aborted"}, aborted,    64'd1);
                check_eq({tag, ":labort_ready"},   prob_ready, 64'd0);
                check_eq({tag, ":labort_rstn"},    core_rstn,  64'd0);
                check_snaps({tag, ":labort"});
                return;
            end
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < int'(gaps); g++) begin
                prob_valid = 1'b0;
                prob_data  = {$urandom, $urandom};
                start      = ($urandom_range(0, 3) == 0);
                tick();
                start = 1'b0;
                check_eq({tag, ":gap_ready"}, prob_ready, 64'd1);
            end
            word       = {$urandom, $urandom};
            prob_valid = 1'b1;
            prob_data  = word;
            tick();
            prob_valid = 1'b0;
            check_eq({tag, ":prob_in"},  probability_in,  word);
            check_eq({tag, ":prob_idx"}, probability_idx, 64'(w));
        end
        check_eq({tag, ":settle_ready"}, prob_ready, 64'd0);

        n = 0;
        while (core_en !== 1'b1 && n < 100) begin
            check_eq({tag, ":settle_rstn"}, core_rstn, 64'd0);
            n++;
            tick();
        end
        check_eq({tag, ":settle_len"}, 64'(n), 64'(c_settle));

        predict_stop(tgt_b, tgt_f, step_b, step_f, max_c, k_stop, reason);
        k_exp = k_stop;
        if (run_abort_k != 0 && (k_stop == 0 || run_abort_k <= k_stop)) k_exp = run_abort_k;
        if (k_exp == 0) k_exp = c_run_limit;

        k = 0;
        while (core_en === 1'b1 && k < c_run_limit) begin
            k++;
            total_bits            = step_b * 64'(k);
            total_frame_errors    = step_f * 64'(k);
            total_frames          = 64'(k) * 3;
            total_bit_errors_pre  = 64'(k) * 5;
            total_bit_errors_post = 64'(k) * 2;
            start = ($urandom_range(0, 7) == 0);
            if (k == run_abort_k) begin
                if (use_rst) rst = 1'b1;
                else         abort = 1'b1;
            end
            tick();
            start = 1'b0; abort = 1'b0; rst = 1'b0;
        end
        check_eq({tag, ":run_len"}, 64'(k), 64'(k_exp));

        if (run_abort_k != 0 && k_exp == run_abort_k) begin
            if (use_rst) begin
                check_reset_state({tag, ":rst"});
            end else begin
                check_eq({tag, ":rabort_busy"},    busy,        64'd0);
                check_eq({tag, ":rabort_en"},      core_en,     64'd0);
                check_eq({tag, ":rabort_rstn"},    core_rstn,   64'd0);
                check_eq({tag, ":rabort_aborted"}, aborted,     64'd1);
                check_eq({tag, ":rabort_done"},    done,        64'd0);
                check_eq({tag, ":rabort_reason"},  stop_reason, 64'd0);
                check_eq({tag, ":rabort_cycles"},  run_cycles,  64'(run_abort_k));
                check_snaps({tag, ":rabort"});
            end
            return;
        end

        if (k_stop == 0) begin
            // No stop condition: still running, cancel with abort
            check_eq({tag, ":still_en"}, core_en, 64'd1);
            abort = 1'b1; tick(); abort = 1'b0;
            check_eq({tag, ":nostop_busy"},    busy,       64'd0);
            check_eq({tag, ":nostop_aborted"}, aborted,    64'd1);
            check_eq({tag, ":nostop_cycles"},  run_cycles, 64'(c_run_limit + 1));
            check_snaps({tag, ":nostop"});
            return;
        end

        // STOP cycle; abort and start here must be ignored
        check_eq({tag, ":stop_en"},     core_en,     64'd0);
        check_eq({tag, ":stop_busy"},   busy,        64'd1);
        check_eq({tag, ":stop_done"},   done,        64'd0);
        check_eq({tag, ":stop_rstn"},   core_rstn,   64'd1);
        check_eq({tag, ":stop_reason"}, stop_reason, 64'(reason));
        check_eq({tag, ":stop_cycles"}, run_cycles,  64'(k_stop));
        snapv[0] = step_b * 64'(k_stop + 1);
        snapv[1] = {$urandom, $urandom};
        snapv[2] = {$urandom, $urandom};
        snapv[3] = {$urandom, $urandom};
        snapv[4] = step_f * 64'(k_stop + 1);
        total_bits            = snapv[0];
        total_bit_errors_pre  = snapv[1];
        total_bit_errors_post = snapv[2];
        total_frames          = snapv[3];
        total_frame_errors    = snapv[4];
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) exp_snap[i] = snapv[i];
        check_eq({tag, ":done"},         done,        64'd1);
        check_eq({tag, ":done_busy"},    busy,        64'd0);
        check_eq({tag, ":done_rstn"},    core_rstn,   64'd1);
        check_eq({tag, ":done_en"},      core_en,     64'd0);
        check_eq({tag, ":done_aborted"}, aborted,     64'd0);
        check_eq({tag, ":done_reason"},  stop_reason, 64'(reason));
        check_eq({tag, ":done_cycles"},  run_cycles,  64'(k_stop));
        check_snaps({tag, ":done"});
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq({tag, ":done_abort_ign"}, done,    64'd1);
        check_eq({tag, ":done_abort_flg"}, aborted, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned tb_b, tf_b, sb, sf;
        int unsigned     kk;
        logic [47:0]     mx;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_target_bits = 0; cfg_target_frame_errors = 0; cfg_max_cycles = 0;
        prob_valid = 1'b0; prob_data = 0;
        total_bits = 0; total_bit_errors_pre = 0; total_bit_errors_post = 0;
        total_frames = 0; total_frame_errors = 0;
        for (int i = 0; i < 5; i++) exp_snap[i] = 64'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_state("reset");

        do_run("bits1000", 1000, 0, 8, 1, 48'd0, -1, 0, 1'b0);

        sb = $urandom_range(1, 20);
        sf = $urandom_range(1, 5);
        kk = $urandom_range(5, 60);
        do_run("same_cycle", sb * kk, sf * kk, sb, sf, 48'd0, -1, 0, 1'b0);

        do_run("frame_only", 0, $urandom_range(20, 300), 3, $urandom_range(1, 4), 48'd0, -1, 0, 1'b0);
        do_run("frame_first", 5000, 40, 10, 2, 48'd0, -1, 0, 1'b0);

        do_run("load_abort", 1000, 0, 8, 1, 48'd0, 2, 0, 1'b0);
        do_run("reload", 200, 0, 4, 1, 48'd0, -1, 0, 1'b0);
        do_run("run_abort", 1000, 0, 8, 1, 48'd0, -1, 40, 1'b0);
        do_run("abort_vs_stop", 1000, 0, 8, 1, 48'd0, -1, 125, 1'b0);
        do_run("timeout", 0, 0, 1, 1, 48'd50, -1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            tb_b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(50, 3000);
            if (tb_b == 0)                     tf_b = $urandom_range(10, 500);
            else if ($urandom_range(0, 1) == 1) tf_b = 0;
            else                               tf_b = $urandom_range(10, 500);
            sb = $urandom_range(1, 20);
            sf = $urandom_range(1, 6);
            mx = ($urandom_range(0, 1) == 1) ? 48'($urandom_range(20, 300)) : 48'd0;
            do_run("random", tb_b, tf_b, sb, sf, mx, -1, 0, 1'b0);
        end

        do_run("rst_mid_run", 0, 0, 1, 1, 48'd0, -1, 30, 1'b1);
        do_run("post_rst", 300, 0, 5, 1, 48'd0, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ber_run_controller.md
BER_RUN_CONTROLLER -- requirements
Module: ber_run_controller

Interface
REQ-001 The block SHALL have parameter N_PROB, default 64, giving the number of Markov probability words loaded per run.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16, giving the cycles core reset is held after the table load completes.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port start SHALL be an input, 1 bit wide: single-cycle run request.
REQ-006 Port abort SHALL be an input, 1 bit wide: cancels the current run.
REQ-007 Ports cfg_target_bits and cfg_target_frame_errors SHALL be inputs, 64 bits each: stop thresholds, where 0 disables that threshold.
REQ-008 Port cfg_max_cycles SHALL be an input, 48 bits wide: RUN timeout, where 0 means unlimited.
REQ-009 Ports prob_valid (input, 1 bit), prob_data (input, 64 bits) and prob_ready (output, 1 bit) SHALL form the probability-table write stream.
REQ-010 Ports core_rstn (output, 1 bit), core_en (output, 1 bit), probability_in (output, 64 bits) and probability_idx (output, 32 bits) SHALL drive the parallel BER core.
REQ-011 Ports total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames and total_frame_errors SHALL be inputs, 64 bits each: live core counters.
REQ-012 Ports snap_bits, snap_err_pre, snap_err_post, snap_frames and snap_frame_err SHALL be outputs, 64 bits each: counters latched at stop.
REQ-013 Ports busy (output, 1 bit), done (output, 1 bit), aborted (output, 1 bit), stop_reason (output, 2 bits) and run_cycles (output, 48 bits) SHALL report status.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, SETTLE, RUN, STOP and DONE.
REQ-015 In IDLE and DONE, a start pulse SHALL go to LOAD and clear done, aborted, stop_reason and run_cycles in that same cycle; start in any other state SHALL be ignored.
REQ-016 In LOAD, prob_ready SHALL be 1, and each cycle where prob_valid and prob_ready are both 1 SHALL drive probability_in=prob_data and probability_idx=word count (0..N_PROB-1) on the next cycle.
REQ-017 After the transfer with index N_PROB-1, the FSM SHALL enter SETTLE, and prob_ready SHALL be 0 in every state other than LOAD.
REQ-018 core_rstn SHALL be 0 in IDLE, LOAD and SETTLE, and 1 in RUN, STOP and DONE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to RUN.
REQ-020 core_en SHALL be 1 only in RUN, and run_cycles SHALL increment once per RUN cycle, saturating at all-ones.
REQ-021 In RUN, a stop SHALL be taken when cfg_target_bits≠0 and total_bits≥cfg_target_bits (reason 1), else when cfg_target_frame_errors≠0 and total_frame_errors≥cfg_target_frame_errors (reason 2), else on a timeout (reason 3, REQ-028); priority SHALL be bits > frame errors > timeout when several hold together.
REQ-022 On a stop the FSM SHALL go RUN→STOP; STOP SHALL last 1 cycle with core_en=0, SHALL latch all five snap_* from the live counters, and SHALL then go to DONE.
REQ-023 If both thresholds are 0 and no timeout applies, RUN SHALL continue until abort.
REQ-024 abort in LOAD, SETTLE or RUN SHALL go to IDLE next cycle, set aborted=1 and leave snap_* unchanged; abort in IDLE, STOP or DONE SHALL be ignored; abort SHALL win over start and over a stop condition in the same cycle.
REQ-025 busy SHALL be 1 in LOAD, SETTLE, RUN and STOP; done SHALL be 1 only in DONE.
REQ-026 Threshold and cfg inputs SHALL be sampled every RUN cycle and need not be held stable by the host.

Reset
REQ-027 On rst=1 at a clk edge the block SHALL enter IDLE and set core_rstn=0, core_en=0, prob_ready=0, probability_in=0, probability_idx=0, all snap_*=0, busy=0, done=0, aborted=0, stop_reason=0, run_cycles=0 and the word and settle counters to 0, overriding any in-flight run.

Configuration
REQ-028 With macro BER_CTRL_TIMEOUT_EN defined, RUN SHALL stop with reason 3 when cfg_max_cycles≠0 and run_cycles equals cfg_max_cycles.
REQ-029 Without BER_CTRL_TIMEOUT_EN, cfg_max_cycles SHALL be ignored and reason 3 SHALL never occur; the port list SHALL be identical in both builds.

Verification
REQ-030 Scenario: N_PROB=4, stream 4 words with prob_valid gaps → probability_idx=0,1,2,3 in order, SETTLE lasts 16 cycles with core_rstn=0, then core_en=1.
REQ-031 Scenario: cfg_target_bits=1000 and total_bits ramping by 8 per cycle → stop_reason=1, snap_bits≥1000, core_en=0 one cycle after the crossing, done=1 next cycle.
REQ-032 Scenario: total_bits and total_frame_errors cross thresholds in the same cycle → stop_reason=1.
REQ-033 Scenario: BER_CTRL_TIMEOUT_EN defined, cfg_max_cycles=50, thresholds 0 → exactly 50 core_en cycles, stop_reason=3; without the macro, RUN persists beyond 1000 cycles.
REQ-034 Scenario: abort during LOAD after 2 words, and separately during RUN → IDLE, aborted=1, snap_* unchanged; a following start reloads from idx 0.
REQ-035 Scenario: rst asserted mid-RUN → all outputs return to their reset values in the next cycle, and start pulses during busy are ignored.
